// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and sizing helper for the parameterised sync FIFO
package sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port register array, synchronous write and asynchronous read
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with count, flags and error pulses; define SYNC_FIFO_FWFT_EN for first-word fall-through reads
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write_en,
  input  logic                          read_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic wr_acc, rd_acc;
  assign wr_acc = write_en && !full;
  assign rd_acc = read_en && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CW'(AFULL_THRESH);
  assign almost_empty = count <= CW'(AEMPTY_THRESH);
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_acc);
      rd_ptr <= rd_ptr + AW'(rd_acc);
      count <= count + CW'(wr_acc) - CW'(rd_acc);
      overflow <= write_en && full;
      underflow <= read_en && empty;
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign out = empty ? '0 : rdata;
`else
  always_ff @(posedge clk or negedge reset)
    if (!reset) out <= '0;
    else if (rd_acc) out <= rdata;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param against a queue reference
module tb_sync_fifo_param;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic write_en = 1'b0;
  logic read_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] out;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  logic [7:0] q [$];
  logic [7:0] last_out = '0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  sync_fifo_param dut (
    .clk(clk),
    .reset(reset),
    .write_en(write_en),
    .read_en(read_en),
    .data_in(data_in),
    .out(out),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_flags();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - 2));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
  endtask
  task automatic op(input bit w, input bit r, input logic [7:0] d);
    bit racc = r && q.size() > 0;
    bit wacc = w && q.size() < DEPTH;
    logic [7:0] e = racc ? q[0] : 8'h00;
`ifdef SYNC_FIFO_FWFT_EN
    if (racc) chk("fwft_head", 32'(out), 32'(e));
`endif
    write_en = w;
    read_en = r;
    data_in = d;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en = 1'b0;
    if (racc) void'(q.pop_front());
    if (wacc) q.push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_out", 32'(out), 32'(q.size() > 0 ? q[0] : 8'h00));
`else
    if (racc) last_out = e;
    chk(racc ? "rd_data" : "out_hold", 32'(out), 32'(last_out));
`endif
    chk("overflow", 32'(overflow), 32'(w && !wacc));
    chk("underflow", 32'(underflow), 32'(r && !racc));
    chk_flags();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_unf", 32'(underflow), 32'h0);
    chk_flags();
    reset = 1'b1;
    op(0, 1, 8'h00);
    op(0, 0, 8'h00);
    op(1, 0, 8'hA1);
    op(1, 0, 8'hB2);
    op(1, 0, 8'hC3);
    op(0, 1, 8'h00);
    op(0, 1, 8'h00);
    op(0, 1, 8'h00);
    for (int i = 0; i < DEPTH; i++) op(1, 0, 8'(8'h10 + i));
    op(1, 0, 8'hFF);
    op(0, 0, 8'h00);
    op(1, 1, 8'hEE);
    for (int i = 0; i < DEPTH - 1; i++) op(0, 1, 8'h00);
    op(1, 1, 8'h55);
    for (int i = 0; i < 4; i++) op(1, 0, 8'(8'h56 + i));
    for (int i = 0; i < 20; i++) op(1, 1, 8'(8'h60 + i));
    for (int i = 0; i < 5; i++) op(0, 1, 8'h00);
    for (int i = 0; i < 40; i++) op(1, q.size() >= 6, 8'(8'h80 + i));
    while (q.size() > 0) op(0, 1, 8'h00);
    for (int i = 0; i < 7; i++) op(1, 0, 8'(8'hC0 + i));
    #3;
    reset = 1'b0;
    #1;
    q.delete();
    last_out = 8'h00;
    chk("async_rst_out", 32'(out), 32'h0);
    chk_flags();
    @(posedge clk);
    #1;
    reset = 1'b1;
    op(1, 0, 8'h3C);
    op(0, 1, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
